// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes, RMW kinds, P-flag indices and
// the RMW sequencer state encoding.
package cpu_pkg;

    localparam logic [4:0] ALU_OP_PASS = 5'd0;
    localparam logic [4:0] ALU_OP_ADC  = 5'd1;
    localparam logic [4:0] ALU_OP_SBC  = 5'd2;
    localparam logic [4:0] ALU_OP_AND  = 5'd3;
    localparam logic [4:0] ALU_OP_ORA  = 5'd4;
    localparam logic [4:0] ALU_OP_INC  = 5'd5;
    localparam logic [4:0] ALU_OP_DEC  = 5'd6;
    localparam logic [4:0] ALU_OP_ASL  = 5'd7;
    localparam logic [4:0] ALU_OP_LSR  = 5'd8;
    localparam logic [4:0] ALU_OP_ROL  = 5'd9;
    localparam logic [4:0] ALU_OP_ROR  = 5'd10;

    localparam logic [2:0] RMW_ASL = 3'd0;
    localparam logic [2:0] RMW_LSR = 3'd1;
    localparam logic [2:0] RMW_ROL = 3'd2;
    localparam logic [2:0] RMW_ROR = 3'd3;
    localparam logic [2:0] RMW_INC = 3'd4;
    localparam logic [2:0] RMW_DEC = 3'd5;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] FMASK_SHIFT  =
        4'((1 << FLAG_N) | (1 << FLAG_Z) | (1 << FLAG_C));
    localparam logic [3:0] FMASK_INCDEC =
        4'((1 << FLAG_N) | (1 << FLAG_Z));

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_DWR  = 3'd2;
    localparam logic [2:0] ST_CALC = 3'd3;
    localparam logic [2:0] ST_MWR  = 3'd4;

endpackage

// File: rtl/rmw_op_decode.sv
// Maps an RMW kind onto the ALU opcode and the P-flag update mask.
// Codes 6 and 7 are reported as illegal.
module rmw_op_decode
    import cpu_pkg::*;
(
    input  logic [2:0] op,
    output logic [4:0] alu_op,
    output logic [3:0] flag_mask,
    output logic       legal
);

    always_comb begin
        alu_op    = ALU_OP_PASS;
        flag_mask = 4'b0000;
        legal     = 1'b1;
        case (op)
            RMW_ASL: begin alu_op = ALU_OP_ASL; flag_mask = FMASK_SHIFT;  end
            RMW_LSR: begin alu_op = ALU_OP_LSR; flag_mask = FMASK_SHIFT;  end
            RMW_ROL: begin alu_op = ALU_OP_ROL; flag_mask = FMASK_SHIFT;  end
            RMW_ROR: begin alu_op = ALU_OP_ROR; flag_mask = FMASK_SHIFT;  end
            RMW_INC: begin alu_op = ALU_OP_INC; flag_mask = FMASK_INCDEC; end
            RMW_DEC: begin alu_op = ALU_OP_DEC; flag_mask = FMASK_INCDEC; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_rmw_sequencer.sv
// Sequences read, optional dummy write, ALU pass and write-back for
// 6502 read-modify-write instructions, then pulses a P-flag update.
module alu_rmw_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter bit DUMMY_WRITE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [4:0]        alu_op,
    output logic [7:0]        alu_a,
    output logic              alu_carry,
    input  logic [7:0]        alu_result,
    input  logic [3:0]        alu_flags,
    output logic              flag_we,
    output logic [3:0]        flag_mask,
    output logic [3:0]        flag_val
);

    logic [2:0]        state_q, state_d;
    logic [4:0]        aluop_q, aluop_d;
    logic [3:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              carry_q, carry_d;
    logic [7:0]        operand_q, operand_d;
    logic [7:0]        result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [4:0] dec_alu_op;
    logic [3:0] dec_mask;
    logic       dec_legal;

    // Decoded once at accept; the latched encoding stands in for op.
    rmw_op_decode u_dec (
        .op        (op),
        .alu_op    (dec_alu_op),
        .flag_mask (dec_mask),
        .legal     (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        aluop_d   = aluop_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        carry_d   = carry_q;
        operand_d = operand_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && dec_legal) begin
                    state_d = ST_RD;
                    aluop_d = dec_alu_op;
                    mask_d  = dec_mask;
                    addr_d  = addr;
                    carry_d = carry_in;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    operand_d = mem_rdata;
                    state_d   = DUMMY_WRITE ? ST_DWR : ST_CALC;
                end
            end
            ST_DWR: begin
                if (mem_ready) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    state_d  = ST_MWR;
                end
            end
            ST_CALC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                state_d  = ST_MWR;
            end
            ST_MWR: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aluop_q   <= '0;
            mask_q    <= '0;
            addr_q    <= '0;
            carry_q   <= 1'b0;
            operand_q <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aluop_q   <= aluop_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            carry_q   <= carry_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        mem_rd    = (state_q == ST_RD);
        mem_wr    = (state_q == ST_DWR) || (state_q == ST_MWR);
        mem_addr  = (mem_rd || mem_wr) ? addr_q : '0;
        mem_wdata = (state_q == ST_DWR) ? operand_q :
                    (state_q == ST_MWR) ? result_q : 8'h00;
        alu_op    = busy ? aluop_q : ALU_OP_PASS;
        alu_a     = busy ? operand_q : 8'h00;
        alu_carry = busy && carry_q;
        done      = done_q;
        err       = err_q;
        flag_we   = done_q;
        flag_mask = done_q ? mask_q : 4'b0000;
        flag_val  = done_q ? flags_q : 4'b0000;
    end

endmodule
